// File: rtl/parking_session_table.sv
// Per-car entry timestamp table: reports parking duration on exit, flags entry/exit errors and tracks occupancy.
// Optional overstay scanner is built when OVERSTAY_SCAN_EN is defined.
module parking_session_table #(
  parameter int NUM_SLOTS = 15,
  parameter int ID_W      = 4,
  parameter int TS_W      = 16,
  parameter int MIN_DUR   = 1,
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TS_W-1:0]  now,
  input  logic             entry_valid,
  input  logic [ID_W-1:0]  entry_id,
  input  logic             exit_valid,
  input  logic [ID_W-1:0]  exit_id,
  output logic             dur_valid,
  output logic [ID_W-1:0]  dur_id,
  output logic [TS_W-1:0]  dur_out,
  output logic [1:0]       entry_err,
  output logic [1:0]       exit_err,
  output logic [CNT_W-1:0] occupancy,
  output logic             full
`ifdef OVERSTAY_SCAN_EN
  ,
  input  logic [TS_W-1:0]  overstay_limit,
  output logic             overstay_valid,
  output logic [ID_W-1:0]  overstay_id
`endif
);

  localparam logic [ID_W-1:0] MAX_ID    = ID_W'(NUM_SLOTS);
  localparam logic [TS_W-1:0] MIN_DUR_V = TS_W'(MIN_DUR);

  logic [NUM_SLOTS-1:0] present_q, present_d;
  logic [TS_W-1:0]      ts_q [NUM_SLOTS];
  logic [TS_W-1:0]      ts_d [NUM_SLOTS];
  logic [CNT_W-1:0]     occupancy_q, occupancy_d;
  logic                 dur_valid_q, dur_valid_d;
  logic [ID_W-1:0]      dur_id_q, dur_id_d;
  logic [TS_W-1:0]      dur_out_q, dur_out_d;
  logic [1:0]           entry_err_q, entry_err_d;
  logic [1:0]           exit_err_q, exit_err_d;

  logic                 entry_id_ok, exit_id_ok, exit_ok, entry_ok;
  logic [NUM_SLOTS-1:0] entry_sel, exit_sel, exit_clr, entry_set, present_mid;
  logic [TS_W-1:0]      exit_ts, exit_age;

  // Session bookkeeping: exit is resolved first so a same-ID entry sees the freed slot.
  always_comb begin
    present_d   = present_q;
    ts_d        = ts_q;
    occupancy_d = occupancy_q;
    dur_valid_d = 1'b0;
    dur_id_d    = dur_id_q;
    dur_out_d   = dur_out_q;
    entry_err_d = 2'b00;
    exit_err_d  = 2'b00;
    exit_ts     = '0;

    entry_id_ok = (entry_id != '0) && (entry_id <= MAX_ID);
    exit_id_ok  = (exit_id != '0) && (exit_id <= MAX_ID);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      entry_sel[i] = entry_valid && entry_id_ok && (entry_id == ID_W'(i + 1));
      exit_sel[i]  = exit_valid && exit_id_ok && (exit_id == ID_W'(i + 1));
      exit_ts      = exit_ts | ({TS_W{exit_sel[i]}} & ts_q[i]);
    end
    exit_ok  = |(exit_sel & present_q);
    exit_age = now - exit_ts;

    if (!exit_valid) begin
      exit_err_d = 2'b00;
    end else if (!exit_id_ok) begin
      exit_err_d = 2'b11;
    end else if (exit_ok) begin
      dur_valid_d = 1'b1;
      dur_id_d    = exit_id;
      dur_out_d   = (exit_age < MIN_DUR_V) ? MIN_DUR_V : exit_age;
    end else begin
      exit_err_d = 2'b10;
    end

    exit_clr    = exit_ok ? exit_sel : '0;
    present_mid = present_q & ~exit_clr;
    entry_ok    = entry_valid && entry_id_ok && ((entry_sel & present_mid) == '0);

    if (!entry_valid) begin
      entry_err_d = 2'b00;
    end else if (!entry_id_ok) begin
      entry_err_d = 2'b11;
    end else if (!entry_ok) begin
      entry_err_d = 2'b01;
    end else begin
      entry_err_d = 2'b00;
    end

    entry_set = entry_ok ? entry_sel : '0;
    present_d = present_mid | entry_set;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ts_d[i] = entry_set[i] ? now : ts_q[i];
    end
    occupancy_d = occupancy_q + CNT_W'(entry_ok) - CNT_W'(exit_ok);
  end

  // Table and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      present_q   <= '0;
      occupancy_q <= '0;
      dur_valid_q <= 1'b0;
      dur_id_q    <= '0;
      dur_out_q   <= '0;
      entry_err_q <= 2'b00;
      exit_err_q  <= 2'b00;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ts_q[i] <= '0;
      end
    end else begin
      present_q   <= present_d;
      occupancy_q <= occupancy_d;
      dur_valid_q <= dur_valid_d;
      dur_id_q    <= dur_id_d;
      dur_out_q   <= dur_out_d;
      entry_err_q <= entry_err_d;
      exit_err_q  <= exit_err_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ts_q[i] <= ts_d[i];
      end
    end
  end

  assign dur_valid = dur_valid_q;
  assign dur_id    = dur_id_q;
  assign dur_out   = dur_out_q;
  assign entry_err = entry_err_q;
  assign exit_err  = exit_err_q;
  assign occupancy = occupancy_q;
  assign full      = (occupancy_q == CNT_W'(NUM_SLOTS));

`ifdef OVERSTAY_SCAN_EN
  logic [ID_W-1:0]      scan_ptr_q, scan_ptr_d;
  logic [NUM_SLOTS-1:0] reported_q, reported_d;
  logic                 overstay_valid_q, overstay_valid_d;
  logic [ID_W-1:0]      overstay_id_q, overstay_id_d;
  logic [NUM_SLOTS-1:0] scan_sel;
  logic [TS_W-1:0]      scan_ts, scan_age;
  logic                 scan_hit;

  // Round-robin scan; a slot leaving this cycle is skipped and its report flag re-armed.
  always_comb begin
    scan_ts = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      scan_sel[i] = (scan_ptr_q == ID_W'(i + 1));
      scan_ts     = scan_ts | ({TS_W{scan_sel[i]}} & ts_q[i]);
    end
    scan_age         = now - scan_ts;
    scan_hit         = (|(scan_sel & present_q & ~reported_q & ~exit_clr)) && (scan_age > overstay_limit);
    overstay_valid_d = scan_hit;
    overstay_id_d    = scan_hit ? scan_ptr_q : overstay_id_q;
    reported_d       = (reported_q & ~exit_clr) | (scan_hit ? scan_sel : '0);
    scan_ptr_d       = (scan_ptr_q >= MAX_ID) ? ID_W'(1) : scan_ptr_q + ID_W'(1);
  end

  // Scanner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_ptr_q       <= ID_W'(1);
      reported_q       <= '0;
      overstay_valid_q <= 1'b0;
      overstay_id_q    <= '0;
    end else begin
      scan_ptr_q       <= scan_ptr_d;
      reported_q       <= reported_d;
      overstay_valid_q <= overstay_valid_d;
      overstay_id_q    <= overstay_id_d;
    end
  end

  assign overstay_valid = overstay_valid_q;
  assign overstay_id    = overstay_id_q;
`endif

endmodule

// File: tb/tb_parking_session_table.sv
// Table-driven bench for parking_session_table with a scoreboard queue of expected responses.
// Overstay scanner sequence runs only when OVERSTAY_SCAN_EN is defined.
module tb_parking_session_table;

  localparam int NUM_SLOTS = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] now;
  logic        entry_valid;
  logic [3:0]  entry_id;
  logic        exit_valid;
  logic [3:0]  exit_id;
  logic        dur_valid;
  logic [3:0]  dur_id;
  logic [15:0] dur_out;
  logic [1:0]  entry_err;
  logic [1:0]  exit_err;
  logic [3:0]  occupancy;
  logic        full;
`ifdef OVERSTAY_SCAN_EN
  logic [15:0] overstay_limit;
  logic        overstay_valid;
  logic [3:0]  overstay_id;
`endif

  parking_session_table dut (
    .clk(clk), .reset(reset), .now(now),
    .entry_valid(entry_valid), .entry_id(entry_id),
    .exit_valid(exit_valid), .exit_id(exit_id),
    .dur_valid(dur_valid), .dur_id(dur_id), .dur_out(dur_out),
    .entry_err(entry_err), .exit_err(exit_err),
    .occupancy(occupancy), .full(full)
`ifdef OVERSTAY_SCAN_EN
    , .overstay_limit(overstay_limit), .overstay_valid(overstay_valid), .overstay_id(overstay_id)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ev;
    logic [3:0]  eid;
    logic        xv;
    logic [3:0]  xid;
    logic [15:0] now;
    logic        dv;
    logic [3:0]  did;
    logic [15:0] dout;
    logic [1:0]  eerr;
    logic [1:0]  xerr;
    logic [3:0]  occ;
    logic        full;
    logic        chk_dur;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  task automatic add(input int rst, input int ev, input int eid, input int xv, input int xid, input int tnow,
                     input int dv, input int did, input int dout, input int eerr, input int xerr,
                     input int occ, input int fl, input int chk);
    vec_t v;
    v.rst = 1'(rst);   v.ev = 1'(ev);     v.eid = 4'(eid);   v.xv = 1'(xv);  v.xid = 4'(xid);
    v.now = 16'(tnow); v.dv = 1'(dv);     v.did = 4'(did);   v.dout = 16'(dout);
    v.eerr = 2'(eerr); v.xerr = 2'(xerr); v.occ = 4'(occ);   v.full = 1'(fl); v.chk_dur = 1'(chk);
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    reset = 1'b0; entry_valid = 1'b0; entry_id = 4'd0; exit_valid = 1'b0; exit_id = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   cnt;
    drive_idle();
    now = 16'd0;
`ifdef OVERSTAY_SCAN_EN
    overstay_limit = 16'hFFFF;
`endif
    //  rst ev eid xv xid now      dv did dout  eerr xerr occ full chk
    add(1, 0, 0, 0, 0, 0,         0, 0, 0,     0, 0, 0,  0, 1);
    add(0, 0, 0, 0, 0, 50,        0, 0, 0,     0, 0, 0,  0, 1);
    add(0, 1, 3, 0, 0, 100,       0, 0, 0,     0, 0, 1,  0, 0);
    add(0, 0, 0, 1, 3, 250,       1, 3, 150,   0, 0, 0,  0, 1);
    add(0, 0, 0, 0, 0, 260,       0, 0, 0,     0, 0, 0,  0, 0);
    add(0, 1, 5, 0, 0, 'hFFF0,    0, 0, 0,     0, 0, 1,  0, 0);
    add(0, 0, 0, 1, 5, 'h0010,    1, 5, 'h20,  0, 0, 0,  0, 1);
    add(0, 1, 2, 0, 0, 40,        0, 0, 0,     0, 0, 1,  0, 0);
    add(0, 0, 0, 1, 2, 40,        1, 2, 1,     0, 0, 0,  0, 1);
    add(0, 1, 4, 0, 0, 300,       0, 0, 0,     0, 0, 1,  0, 0);
    add(0, 1, 4, 0, 0, 310,       0, 0, 0,     1, 0, 1,  0, 0);
    add(0, 0, 0, 1, 4, 400,       1, 4, 100,   0, 0, 0,  0, 1);
    add(0, 0, 0, 1, 7, 400,       0, 0, 0,     0, 2, 0,  0, 0);
    add(0, 1, 0, 0, 0, 400,       0, 0, 0,     3, 0, 0,  0, 0);
    add(0, 0, 0, 1, 0, 400,       0, 0, 0,     0, 3, 0,  0, 0);
    add(0, 1, 2, 1, 2, 45,        0, 0, 0,     0, 2, 1,  0, 0);
    add(0, 0, 0, 1, 2, 60,        1, 2, 15,    0, 0, 0,  0, 1);
    for (int id = 1; id <= NUM_SLOTS; id++)
      add(0, 1, id, 0, 0, 200,    0, 0, 0,     0, 0, id, (id == NUM_SLOTS) ? 1 : 0, 0);
    add(0, 1, 9, 1, 9, 500,       1, 9, 300,   0, 0, 15, 1, 1);
    add(0, 0, 0, 1, 9, 600,       1, 9, 100,   0, 0, 14, 0, 1);
    add(0, 1, 9, 1, 1, 700,       1, 1, 500,   0, 0, 14, 0, 1);
    add(0, 1, 1, 0, 0, 700,       0, 0, 0,     0, 0, 15, 1, 0);
    add(0, 1, 1, 0, 0, 710,       0, 0, 0,     1, 0, 15, 1, 0);
    add(1, 0, 0, 0, 0, 0,         0, 0, 0,     0, 0, 0,  0, 1);
    add(0, 1, 6, 0, 0, 10,        0, 0, 0,     0, 0, 1,  0, 1);
    add(1, 0, 0, 1, 6, 20,        0, 0, 0,     0, 0, 0,  0, 1);
    add(0, 0, 0, 1, 6, 30,        0, 0, 0,     0, 2, 0,  0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset = vecs[k].rst; entry_valid = vecs[k].ev; entry_id = vecs[k].eid;
      exit_valid = vecs[k].xv; exit_id = vecs[k].xid; now = vecs[k].now;
      sb.push_back(vecs[k]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("dur_valid", k, 32'(dur_valid), 32'(e.dv));
      check("entry_err", k, 32'(entry_err), 32'(e.eerr));
      check("exit_err", k, 32'(exit_err), 32'(e.xerr));
      check("occupancy", k, 32'(occupancy), 32'(e.occ));
      check("full", k, 32'(full), 32'(e.full));
      if (e.chk_dur) begin
        check("dur_id", k, 32'(dur_id), 32'(e.did));
        check("dur_out", k, 32'(dur_out), 32'(e.dout));
      end
    end

`ifdef OVERSTAY_SCAN_EN
    @(negedge clk); drive_idle(); reset = 1'b1; now = 16'd0;
    @(posedge clk); #1;
    @(negedge clk); drive_idle(); overstay_limit = 16'd50;
    entry_valid = 1'b1; entry_id = 4'd1; now = 16'd0;
    @(posedge clk); #1;
    check("ovs_reset_quiet", 0, 32'(overstay_valid), 32'd0);
    @(negedge clk); drive_idle(); now = 16'd100;
    cnt = 0;
    repeat (NUM_SLOTS + 2) begin
      @(posedge clk); #1;
      if (overstay_valid) begin
        cnt++;
        check("ovs_id", 1, 32'(overstay_id), 32'd1);
      end
    end
    check("ovs_first_count", 1, 32'(cnt), 32'd1);
    cnt = 0;
    repeat (3 * NUM_SLOTS) begin
      @(posedge clk); #1;
      if (overstay_valid) cnt++;
    end
    check("ovs_no_repeat", 2, 32'(cnt), 32'd0);
    @(negedge clk); exit_valid = 1'b1; exit_id = 4'd1;
    @(posedge clk); #1;
    check("ovs_exit_dur", 3, 32'(dur_out), 32'd100);
    @(negedge clk); drive_idle(); entry_valid = 1'b1; entry_id = 4'd1;
    @(posedge clk); #1;
    @(negedge clk); drive_idle(); now = 16'd200;
    cnt = 0;
    repeat (NUM_SLOTS + 2) begin
      @(posedge clk); #1;
      if (overstay_valid) begin
        cnt++;
        check("ovs_rearm_id", 4, 32'(overstay_id), 32'd1);
      end
    end
    check("ovs_rearm_count", 4, 32'(cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
